// File: rtl/dcache_pkg.sv
// Shared constants, FSM state encodings and sizing helper for the MEM-stage data cache.
package dcache_pkg;

  localparam int OFFSET_W   = 5;
  localparam int WORD_SEL_W = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_WRITEBACK = 2'd1;
  localparam state_t ST_REFILL    = 2'd2;

  function automatic int index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side request/stall port and line-granular memory port of the data cache.
interface dcache_if #(
  parameter int LINE_BITS = 256
);
  // Handshakes: a CPU access is offered while p1_req_i is high and completes in the
  // first cycle p1_stall_o is low; the requester holds all p1_* inputs stable while
  // stalled. A memory request is offered while mem_enable_o is high, with
  // write/addr/data held constant, and completes in the cycle mem_ack_i pulses.
  logic                 p1_req_i;
  logic                 p1_write_i;
  logic [31:0]          p1_addr_i;
  logic [31:0]          p1_data_i;
  logic [31:0]          p1_data_o;
  logic                 p1_stall_o;
  logic                 mem_enable_o;
  logic                 mem_write_o;
  logic [31:0]          mem_addr_o;
  logic [LINE_BITS-1:0] mem_data_o;
  logic [LINE_BITS-1:0] mem_data_i;
  logic                 mem_ack_i;

  modport slave (
    input  p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
    output p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
    input  p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

endinterface

// File: rtl/dcache_sram.sv
// Register-array line store: valid/dirty/tag/data with async read and two sync write ports.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int LINE_BITS = 256,
  parameter int TAG_W     = 22,
  parameter int INDEX_W   = index_w(NUM_LINES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_W-1:0]    index,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [LINE_BITS-1:0]  rd_data,
  input  logic                  fill_en,
  input  logic [TAG_W-1:0]      fill_tag,
  input  logic [LINE_BITS-1:0]  fill_data,
  input  logic                  store_en,
  input  logic [WORD_SEL_W-1:0] store_word,
  input  logic [31:0]           store_data
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_data  = data_q[index];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (store_en) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tag and data hold no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[index]  <= fill_tag;
      data_q[index] <= fill_data;
    end else if (store_en) begin
      data_q[index][{store_word, 5'd0} +: 32] <= store_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller: hit logic, miss FSM, memory port.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int LINE_BITS = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  dcache_if.slave     bus,
  output state_t      dbg_state
);

  localparam int INDEX_W = index_w(NUM_LINES);
  localparam int TAG_W   = 32 - OFFSET_W - INDEX_W;

  state_t               state_q;
  logic                 mem_enable_q;
  logic                 mem_write_q;
  logic [31:0]          mem_addr_q;
  logic [LINE_BITS-1:0] mem_data_q;

  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_W-1:0]    req_index;
  logic [WORD_SEL_W-1:0] req_word;
  logic                  rd_valid;
  logic                  rd_dirty;
  logic [TAG_W-1:0]      rd_tag;
  logic [LINE_BITS-1:0]  rd_data;
  logic                  in_idle;
  logic                  hit;
  logic                  store_en;
  logic                  fill_en;
  logic                  unused_addr_bits;

  assign req_tag          = bus.p1_addr_i[31 -: TAG_W];
  assign req_index        = bus.p1_addr_i[OFFSET_W +: INDEX_W];
  assign req_word         = bus.p1_addr_i[2 +: WORD_SEL_W];
  assign unused_addr_bits = ^bus.p1_addr_i[1:0];

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .LINE_BITS (LINE_BITS),
    .TAG_W     (TAG_W),
    .INDEX_W   (INDEX_W)
  ) u_sram (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .index      (req_index),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_tag     (rd_tag),
    .rd_data    (rd_data),
    .fill_en    (fill_en),
    .fill_tag   (req_tag),
    .fill_data  (bus.mem_data_i),
    .store_en   (store_en),
    .store_word (req_word),
    .store_data (bus.p1_data_i)
  );

  // Hits are only recognised in IDLE, so a refilled request hits on its re-check cycle.
  assign in_idle  = (state_q == ST_IDLE);
  assign hit      = in_idle & bus.p1_req_i & rd_valid & (rd_tag == req_tag);
  assign store_en = hit & bus.p1_write_i;
  assign fill_en  = (state_q == ST_REFILL) & bus.mem_ack_i;

  assign bus.p1_stall_o   = in_idle ? (bus.p1_req_i & ~hit) : 1'b1;
  assign bus.p1_data_o    = (hit & ~bus.p1_write_i) ? rd_data[{req_word, 5'd0} +: 32] : 32'd0;
  assign bus.mem_enable_o = mem_enable_q;
  assign bus.mem_write_o  = mem_write_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_data_o   = mem_data_q;
  assign dbg_state        = state_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.p1_req_i && !hit) begin
            mem_enable_q <= 1'b1;
            if (rd_valid && rd_dirty) begin
              state_q     <= ST_WRITEBACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {rd_tag, req_index, {OFFSET_W{1'b0}}};
              mem_data_q  <= rd_data;
            end else begin
              state_q     <= ST_REFILL;
              mem_write_q <= 1'b0;
              mem_addr_q  <= {req_tag, req_index, {OFFSET_W{1'b0}}};
            end
          end
        end
        // Enable stays high across the write-back ack so the fill follows without a gap.
        ST_WRITEBACK: begin
          if (bus.mem_ack_i) begin
            state_q     <= ST_REFILL;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {req_tag, req_index, {OFFSET_W{1'b0}}};
          end
        end
        ST_REFILL: begin
          if (bus.mem_ack_i) begin
            state_q      <= ST_IDLE;
            mem_enable_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          mem_enable_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios plus random traffic against a line-level cache model.
`timescale 1ns/1ps
module tb_dcache_ctrl;
  import dcache_pkg::*;

  localparam int NUM_LINES    = 32;
  localparam int LINE_BITS    = 256;
  localparam int TAG_W        = 22;
  localparam int W            = 1 + 32 + LINE_BITS;
  localparam int STALL_BUDGET = 200;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;

  dcache_if #(.LINE_BITS(LINE_BITS)) bus ();

  dcache_ctrl #(.NUM_LINES(NUM_LINES), .LINE_BITS(LINE_BITS)) dut (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [LINE_BITS-1:0] act,
                       input logic [LINE_BITS-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: cache contents as plain arrays, backing memory as a sparse map.
  bit                   m_valid [NUM_LINES];
  bit                   m_dirty [NUM_LINES];
  logic [TAG_W-1:0]     m_tag   [NUM_LINES];
  logic [LINE_BITS-1:0] m_data  [NUM_LINES];
  logic [LINE_BITS-1:0] model_mem [logic [31:0]];
  logic [LINE_BITS-1:0] env_mem   [logic [31:0]];
  logic [W-1:0]         exp_q[$];

  function automatic logic [LINE_BITS-1:0] init_line(input logic [31:0] la);
    logic [LINE_BITS-1:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = (la + 32'(w * 4)) ^ 32'hA5A5_0000;
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // Memory responder: acks after a per-phase latency counted in enabled cycles.
  int lat_wb = 1;
  int lat_rf = 1;
  bit spur_ack = 1'b0;

  initial begin
    int mcnt;
    mcnt = 0;
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      if (spur_ack) begin
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = {8{$urandom}};
      end else if (rst_n && bus.mem_enable_o) begin
        mcnt++;
        if (mcnt >= (bus.mem_write_o ? lat_wb : lat_rf)) begin
          mcnt = 0;
          bus.mem_ack_i = 1'b1;
          if (bus.mem_write_o) env_mem[bus.mem_addr_o] = bus.mem_data_o;
          else bus.mem_data_i = env_mem.exists(bus.mem_addr_o) ? env_mem[bus.mem_addr_o]
                                                               : init_line(bus.mem_addr_o);
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  // Per-cycle compare: memory transactions against exp_q, request hold, idle outputs.
  logic [31:0]          last_wb_addr = '0;
  logic [LINE_BITS-1:0] last_wb_data = '0;

  initial begin
    logic [W-1:0]         e;
    bit                   prev_en, prev_ack;
    logic [32:0]          prev_ctl;
    logic [LINE_BITS-1:0] prev_data;
    prev_en = 1'b0; prev_ack = 1'b0; prev_ctl = '0; prev_data = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        if (bus.mem_ack_i && !spur_ack) begin
          if (exp_q.size() == 0) begin
            check("mem_txn_unexpected", {bus.mem_write_o, bus.mem_addr_o}, '1);
          end else begin
            e = exp_q.pop_front();
            check("mem_enable", bus.mem_enable_o, 1'b1);
            check("mem_write", bus.mem_write_o, e[W-1]);
            check("mem_addr", bus.mem_addr_o, e[W-2 -: 32]);
            if (e[W-1]) begin
              check("mem_wb_data", bus.mem_data_o, e[LINE_BITS-1:0]);
              last_wb_addr = bus.mem_addr_o;
              last_wb_data = bus.mem_data_o;
            end
          end
        end
        if (prev_en && !prev_ack && bus.mem_enable_o) begin
          check("mem_hold_ctl", {bus.mem_write_o, bus.mem_addr_o}, prev_ctl);
          if (bus.mem_write_o) check("mem_hold_data", bus.mem_data_o, prev_data);
        end
        if (!bus.p1_req_i) begin
          check("idle_stall", bus.p1_stall_o, 1'b0);
          check("idle_data", bus.p1_data_o, 32'd0);
        end
        prev_en   = bus.mem_enable_o;
        prev_ack  = bus.mem_ack_i;
        prev_ctl  = {bus.mem_write_o, bus.mem_addr_o};
        prev_data = bus.mem_data_o;
      end else begin
        prev_en = 1'b0;
      end
    end
  end

  // Driver: the model predicts the transactions, stall length and load data first.
  task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int lwb, input int lrf, output int stalls,
                           output logic [31:0] rdata);
    logic [4:0]       idx;
    logic [TAG_W-1:0] tag;
    logic [31:0]      la, vla, exp_data;
    int               wi, exp_stall;
    bit               done;
    idx = addr[9:5];
    tag = addr[31:10];
    wi  = int'(addr[4:2]);
    la  = {addr[31:5], 5'b0};
    exp_stall = 0;
    if (!(m_valid[idx] && m_tag[idx] == tag)) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        vla = {m_tag[idx], idx, 5'b0};
        exp_q.push_back({1'b1, vla, m_data[idx]});
        model_mem[vla] = m_data[idx];
        exp_stall += lwb;
      end
      exp_q.push_back({1'b0, la, {LINE_BITS{1'b0}}});
      exp_stall += lrf + 1;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
      m_data[idx]  = model_mem.exists(la) ? model_mem[la] : init_line(la);
    end
    if (wr) begin
      m_data[idx][wi*32 +: 32] = wdata;
      m_dirty[idx] = 1'b1;
    end
    exp_data = wr ? 32'd0 : m_data[idx][wi*32 +: 32];

    lat_wb = lwb;
    lat_rf = lrf;
    bus.p1_req_i   = 1'b1;
    bus.p1_write_i = wr;
    bus.p1_addr_i  = addr;
    bus.p1_data_i  = wdata;
    stalls = 0;
    done   = 1'b0;
    while (!done) begin
      #2;
      if (bus.p1_stall_o) begin
        stalls++;
        if (stalls > STALL_BUDGET) begin
          check("stall_timeout", stalls, exp_stall);
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end else begin
        done = 1'b1;
      end
    end
    rdata = bus.p1_data_o;
    check("stall_cycles", stalls, exp_stall);
    check("p1_data", rdata, exp_data);
    @(negedge clk);
    bus.p1_req_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s;
    logic [31:0] d;
    logic [31:0] a;
    bus.p1_req_i   = 1'b0;
    bus.p1_write_i = 1'b0;
    bus.p1_addr_i  = '0;
    bus.p1_data_i  = '0;
    model_reset();
    repeat (3) @(negedge clk);

    check("rst_mem_enable", bus.mem_enable_o, 1'b0);
    check("rst_mem_write", bus.mem_write_o, 1'b0);
    check("rst_mem_addr", bus.mem_addr_o, 32'd0);
    check("rst_mem_data", bus.mem_data_o, '0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_stall_noreq", bus.p1_stall_o, 1'b0);
    bus.p1_req_i  = 1'b1;
    bus.p1_addr_i = 32'h40;
    #1;
    check("rst_stall_req", bus.p1_stall_o, 1'b1);
    check("rst_data_req", bus.p1_data_o, 32'd0);
    bus.p1_req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_access(1'b0, 32'h0000_0040, 32'd0, 1, 10, s, d);
    check("t1_stall", s, 11);
    check("t1_data", d, 32'hA5A5_0040);

    do_access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 1, 1, s, d);
    check("t2_store_stall", s, 0);
    do_access(1'b0, 32'h0000_0044, 32'd0, 1, 1, s, d);
    check("t2_load_stall", s, 0);
    check("t2_load_data", d, 32'hDEAD_BEEF);

    do_access(1'b0, 32'h0000_0440, 32'd0, 3, 4, s, d);
    check("t3_stall", s, 8);
    check("t3_wb_addr", last_wb_addr, 32'h40);
    check("t3_wb_word1", last_wb_data[63:32], 32'hDEAD_BEEF);
    check("t3_data", d, 32'hA5A5_0440);

    do_access(1'b1, 32'h0000_0880, 32'h1234_5678, 1, 5, s, d);
    check("t4_store_stall", s, 6);
    do_access(1'b0, 32'h0000_0880, 32'd0, 1, 1, s, d);
    check("t4_load_data", d, 32'h1234_5678);

    // Abandon a refill with an asynchronous reset; the dirty 0x880 line is lost.
    lat_rf = 10;
    bus.p1_req_i   = 1'b1;
    bus.p1_write_i = 1'b0;
    bus.p1_addr_i  = 32'h0000_1040;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_enable_drop", bus.mem_enable_o, 1'b0);
    check("t5_state", dbg_state, ST_IDLE);
    check("t5_stall_req", bus.p1_stall_o, 1'b1);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    bus.p1_req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_access(1'b0, 32'h0000_1040, 32'd0, 1, 3, s, d);
    check("t5_refetch_stall", s, 4);
    check("t5_refetch_data", d, 32'hA5A5_1040);
    do_access(1'b0, 32'h0000_0880, 32'd0, 1, 2, s, d);
    check("t5_lost_dirty", d, 32'hA5A5_0880);

    // Spurious ack while idle must not disturb state or arrays.
    @(posedge clk);
    #1 spur_ack = 1'b1;
    @(negedge clk);
    #2;
    check("t6_stall", bus.p1_stall_o, 1'b0);
    @(posedge clk);
    #1 spur_ack = 1'b0;
    @(negedge clk);
    #2;
    check("t6_state", dbg_state, ST_IDLE);
    check("t6_enable", bus.mem_enable_o, 1'b0);
    @(negedge clk);
    do_access(1'b0, 32'h0000_1040, 32'd0, 1, 1, s, d);
    check("t6_hit_stall", s, 0);
    check("t6_hit_data", d, 32'hA5A5_1040);

    // Random traffic over a few indices and tags to force conflicts and evictions.
    for (int i = 0; i < 300; i++) begin
      a = {22'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
      do_access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 6),
                $urandom_range(1, 6), s, d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
